// File: rtl/led_scanner.sv
// LED bar scanner: a BAR-wide lit bar moves across a WIDTH-LED strip, paced by an
// internal step prescaler. Bounce (with end dwell), rotate left/right and hold modes.
module led_scanner #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned BAR   = 2,
    parameter int unsigned START = 5,
    parameter int unsigned DIV   = 1000000,
    parameter int unsigned DWELL = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] led,
    output logic             dir,
    output logic             step
);

    localparam int unsigned    CW           = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  CNT_MAX      = CW'(DIV - 1);
    localparam logic [63:0]    BAR_MASK     = (64'd1 << BAR) - 64'd1;
    localparam logic [WIDTH-1:0] LED_INIT   = WIDTH'(BAR_MASK << START);
    localparam logic [7:0]     DWELL_RELOAD = 8'(DWELL - 1);

    typedef enum logic [1:0] {
        ModeBounce = 2'b00,
        ModeRotL   = 2'b01,
        ModeRotR   = 2'b10,
        ModeHold   = 2'b11
    } mode_e;

    if (WIDTH < 2 || WIDTH > 32 || BAR < 1 || BAR > WIDTH - 1 || START + BAR > WIDTH ||
        DIV < 1 || DWELL > 255) begin : g_param_err
        $error("led_scanner: illegal parameter combination");
    end

    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_led;
    logic             r_dir;
    logic             r_step;
    logic [7:0]       r_dwell;

    logic             w_tick;
    logic [WIDTH-1:0] w_rotl;
    logic [WIDTH-1:0] w_rotr;
    logic [WIDTH-1:0] w_shl;
    logic [WIDTH-1:0] w_shr;
    logic             w_wrapped;
    logic             w_at_edge;
    logic [WIDTH-1:0] w_led_d;
    logic             w_dir_d;
    logic [7:0]       w_dwell_d;

    assign w_tick    = en && (r_cnt == CNT_MAX);
    assign w_rotl    = {r_led[WIDTH-2:0], r_led[WIDTH-1]};
    assign w_rotr    = {r_led[0], r_led[WIDTH-1:1]};
    assign w_shl     = r_led << 1;
    assign w_shr     = r_led >> 1;
    assign w_wrapped = r_led[0] & r_led[WIDTH-1];
    assign w_at_edge = r_dir ? r_led[0] : r_led[WIDTH-1];

    // Candidate next pattern; only committed on a step tick.
    always_comb begin
        w_led_d   = r_led;
        w_dir_d   = r_dir;
        w_dwell_d = r_dwell;
        case (mode_e'(mode))
            ModeRotL: begin
                w_led_d   = w_rotl;
                w_dir_d   = 1'b0;
                w_dwell_d = 8'd0;
            end
            ModeRotR: begin
                w_led_d   = w_rotr;
                w_dir_d   = 1'b1;
                w_dwell_d = 8'd0;
            end
            ModeHold: begin
                w_led_d = r_led;
            end
            default: begin
                if (w_wrapped) begin
                    // A bar straddling both ends can only be un-wrapped by rotating.
                    w_led_d = r_dir ? w_rotr : w_rotl;
                end else if (r_dwell != 8'd0) begin
                    w_dwell_d = r_dwell - 8'd1;
                end else if (w_at_edge) begin
                    w_dir_d = ~r_dir;
                    if (DWELL == 0) begin
                        w_led_d = r_dir ? w_shl : w_shr;
                    end else begin
                        w_dwell_d = DWELL_RELOAD;
                    end
                end else begin
                    w_led_d = r_dir ? w_shr : w_shl;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_led   <= LED_INIT;
            r_dir   <= 1'b0;
            r_step  <= 1'b0;
            r_dwell <= 8'd0;
        end else begin
            r_step <= w_tick;
            if (en) begin
                r_cnt <= (r_cnt == CNT_MAX) ? '0 : r_cnt + 1'b1;
            end
            if (w_tick) begin
                r_led   <= w_led_d;
                r_dir   <= w_dir_d;
                r_dwell <= w_dwell_d;
            end
        end
    end

    assign led  = r_led;
    assign dir  = r_dir;
    assign step = r_step;

endmodule

// File: tb/tb_led_scanner.sv
// Bench for led_scanner: three instances (DWELL = 1, 0, 3) share stimulus; a bar-position
// model is compared every cycle, plus directed literal checks.
module tb_led_scanner;

    localparam int W     = 12;
    localparam int BAR   = 2;
    localparam int START = 5;
    localparam int DIV   = 4;
    localparam int NI    = 3;
    localparam int DWS [NI] = '{1, 0, 3};

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         en    = 1'b0;
    logic [1:0]   mode  = 2'b00;
    logic [W-1:0] d_led  [NI];
    logic         d_dir  [NI];
    logic         d_step [NI];

    always #5 clk = ~clk;

    led_scanner #(.WIDTH(W), .BAR(BAR), .START(START), .DIV(DIV), .DWELL(1)) u_dw1 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
        .led(d_led[0]), .dir(d_dir[0]), .step(d_step[0])
    );
    led_scanner #(.WIDTH(W), .BAR(BAR), .START(START), .DIV(DIV), .DWELL(0)) u_dw0 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
        .led(d_led[1]), .dir(d_dir[1]), .step(d_step[1])
    );
    led_scanner #(.WIDTH(W), .BAR(BAR), .START(START), .DIV(DIV), .DWELL(3)) u_dw3 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
        .led(d_led[2]), .dir(d_dir[2]), .step(d_step[2])
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Model: bar tracked as the index of its lowest lit LED, modulo W.
    int m_pos   [NI];
    bit m_dir   [NI];
    int m_dwell [NI];
    int m_cnt;
    bit m_step;
    bit m_valid = 1'b0;

    function automatic logic [W-1:0] bar_at(input int pos);
        logic [W-1:0] v = '0;
        for (int i = 0; i < BAR; i++) v[(pos + i) % W] = 1'b1;
        return v;
    endfunction

    function automatic int move(input int pos, input bit to_lsb);
        return to_lsb ? (pos + W - 1) % W : (pos + 1) % W;
    endfunction

    task automatic model_tick(input int k);
        bit wrapped = (m_pos[k] + BAR > W);
        bit at_end  = m_dir[k] ? (m_pos[k] == 0) : (m_pos[k] == W - BAR);
        case (mode)
            2'b01: begin m_pos[k] = move(m_pos[k], 1'b0); m_dir[k] = 1'b0; m_dwell[k] = 0; end
            2'b10: begin m_pos[k] = move(m_pos[k], 1'b1); m_dir[k] = 1'b1; m_dwell[k] = 0; end
            2'b11: ;
            default: begin
                if (wrapped) m_pos[k] = move(m_pos[k], m_dir[k]);
                else if (m_dwell[k] > 0) m_dwell[k]--;
                else if (at_end) begin
                    m_dir[k] = !m_dir[k];
                    if (DWS[k] == 0) m_pos[k] = move(m_pos[k], m_dir[k]);
                    else m_dwell[k] = DWS[k] - 1;
                end else m_pos[k] = move(m_pos[k], m_dir[k]);
            end
        endcase
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NI; k++) begin
                m_pos[k] = START; m_dir[k] = 1'b0; m_dwell[k] = 0;
            end
            m_cnt = 0; m_step = 1'b0; m_valid = 1'b1;
        end else if (en) begin
            m_step = (m_cnt == DIV - 1);
            if (m_step) for (int k = 0; k < NI; k++) model_tick(k);
            m_cnt = (m_cnt + 1) % DIV;
        end else begin
            m_step = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            for (int k = 0; k < NI; k++) begin
                chk($sformatf("model_led[%0d]", k), 32'(d_led[k]), 32'(bar_at(m_pos[k])));
                chk($sformatf("model_dir[%0d]", k), 32'(d_dir[k]), 32'(m_dir[k]));
                chk($sformatf("model_step[%0d]", k), 32'(d_step[k]), 32'(m_step));
            end
        end
    end

    // Returns at the negedge where step is seen; ncyc counts rising edges waited.
    task automatic wait_tick(output int ncyc);
        ncyc = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            ncyc++;
            @(negedge clk);
            if (d_step[0]) return;
        end
        checks++;
        errors++;
        $display("FAIL tick_timeout: no step within 50 cycles, expected one");
    endtask

    task automatic lit(input string name, input int k, input logic [W-1:0] eled, input bit edir);
        chk($sformatf("%s_led[%0d]", name, k), 32'(d_led[k]), 32'(eled));
        chk($sformatf("%s_dir[%0d]", name, k), 32'(d_dir[k]), 32'(edir));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            lit("reset", k, 12'h060, 1'b0);
            chk($sformatf("reset_step[%0d]", k), 32'(d_step[k]), 32'd0);
        end
        rst_n = 1'b1;
    endtask

    logic [W-1:0] exp_bounce [NI][9] = '{
        '{12'h0C0, 12'h180, 12'h300, 12'h600, 12'hC00, 12'hC00, 12'h600, 12'h300, 12'h180},
        '{12'h0C0, 12'h180, 12'h300, 12'h600, 12'hC00, 12'h600, 12'h300, 12'h180, 12'h0C0},
        '{12'h0C0, 12'h180, 12'h300, 12'h600, 12'hC00, 12'hC00, 12'hC00, 12'hC00, 12'h600}
    };

    initial begin
        int n;
        mode = 2'b00;
        en   = 1'b1;
        do_reset();

        // Bounce across the strip and back for all three dwell settings.
        for (int t = 1; t <= 16; t++) begin
            wait_tick(n);
            chk($sformatf("step_spacing_t%0d", t), 32'(n), (t == 12) ? 32'd2 : 32'd4);
            if (t <= 9) begin
                for (int k = 0; k < NI; k++) begin
                    chk($sformatf("bounce_t%0d_led[%0d]", t, k), 32'(d_led[k]),
                        32'(exp_bounce[k][t-1]));
                end
            end
            if (t == 6) for (int k = 0; k < NI; k++) chk("edge_dir", 32'(d_dir[k]), 32'd1);
            if (t == 15) lit("left_end", 1, 12'h003, 1'b1);
            if (t == 16) lit("left_reverse", 1, 12'h006, 1'b0);
            if (t == 11) begin
                // Mode glitch between ticks must have no effect.
                @(posedge clk); #1 mode = 2'b11;
                @(posedge clk); #1 mode = 2'b00;
            end
        end

        // Rotate left, rotate right, wrapped bar in bounce, hold.
        do_reset();
        for (int t = 1; t <= 5; t++) wait_tick(n);
        lit("pre_rot", 0, 12'hC00, 1'b0);
        mode = 2'b01;
        wait_tick(n);
        for (int k = 0; k < NI; k++) lit("rotl1", k, 12'h801, 1'b0);
        wait_tick(n);
        for (int k = 0; k < NI; k++) lit("rotl2", k, 12'h003, 1'b0);
        mode = 2'b10;
        wait_tick(n);
        for (int k = 0; k < NI; k++) lit("rotr1", k, 12'h801, 1'b1);
        mode = 2'b00;
        wait_tick(n);
        for (int k = 0; k < NI; k++) lit("wrap_bounce", k, 12'hC00, 1'b1);
        wait_tick(n);
        mode = 2'b11;
        wait_tick(n);
        chk("hold_spacing", 32'(n), 32'd4);
        lit("hold", 0, 12'h600, 1'b1);
        mode = 2'b00;

        // Freeze for 10 cycles at prescaler count 2.
        @(posedge clk);
        @(posedge clk);
        #1 en = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        lit("frozen", 0, 12'h600, 1'b1);
        chk("frozen_step", 32'(d_step[0]), 32'd0);
        en = 1'b1;
        wait_tick(n);
        chk("resume_latency", 32'(n), 32'd2);
        lit("resume", 0, 12'h300, 1'b1);

        // Reset in the middle of the DWELL=3 hold and mid prescaler count.
        do_reset();
        for (int t = 1; t <= 6; t++) wait_tick(n);
        lit("in_dwell", 2, 12'hC00, 1'b1);
        @(posedge clk);
        @(posedge clk);
        do_reset();
        wait_tick(n);
        chk("post_reset_latency", 32'(n), 32'd4);
        lit("post_reset", 2, 12'h0C0, 1'b0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
